// File: rtl/sfifo_pkt_abt.sv
// sfifo_pkt_abt: single-clock packet FIFO with speculative writes.
// Words land in storage at a speculative pointer and become visible to the
// reader only when the packet's EOT word is committed. An abort, or an EOT on
// a packet poisoned by an overflow, rolls the speculative pointer back to the
// last committed position. Depth need not be a power of two.
// Optional build macro: SFIFO_PKT_ABT_RD_EOT_EN adds a stored eot bit per
// entry and an rd_eot output that delimits packets on the read side.
module sfifo_pkt_abt #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 8,
    parameter int AF_MARGIN = 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             eot,
    input  logic             abort,
    output logic             full,
    output logic             full_n,
    output logic             afull,
    output logic             empty,
    output logic             empty_n,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] data_cnt,
    output logic [CNT_W-1:0] free_cnt,
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
    output logic             rd_eot,
`endif
    output logic             drop,
    output logic             ovf
);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_MARGIN);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    // Pointer increment with wrap at DEPTH-1, so any depth works.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] r;
        if (p == LAST_C) begin
            r = ADDR_W'(0);
        end else begin
            r = p + ADDR_W'(1);
        end
        return r;
    endfunction

    logic [WIDTH-1:0]  mem_q [DEPTH];
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
    logic              eot_mem_q [DEPTH];
`endif
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] tmp_ptr_q, tmp_ptr_d;
    logic [CNT_W-1:0]  spec_cnt_q, spec_cnt_d;
    logic [CNT_W-1:0]  cmt_cnt_q, cmt_cnt_d;
    logic              bad_q, bad_d;
    logic              full_q, afull_q, empty_q, drop_q, ovf_q;
    logic [CNT_W-1:0]  data_cnt_q, free_cnt_q, free_cnt_d;

    logic              wr_acc_s, rd_acc_s, ovf_s, drop_s, commit_s, rollback_s;
    logic [CNT_W-1:0]  spec_adv_s;

    // Accept decisions and next-state pointers, counters and poison bit.
    always_comb begin
        wr_acc_s   = wr_en & ~full_q & ~abort;
        rd_acc_s   = rd_en & ~empty_q;
        ovf_s      = wr_en & full_q & ~abort;
        // A poisoned packet (poisoned earlier or right now) is discarded at its EOT.
        drop_s     = wr_en & eot & ~abort & (bad_q | ovf_s);
        commit_s   = wr_acc_s & eot & ~bad_q;
        rollback_s = abort | drop_s;
        spec_adv_s = spec_cnt_q + CNT_W'(wr_acc_s) - CNT_W'(rd_acc_s);

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tmp_ptr_d  = tmp_ptr_q;
        spec_cnt_d = spec_adv_s;
        cmt_cnt_d  = cmt_cnt_q - CNT_W'(rd_acc_s);
        bad_d      = bad_q;

        if (rd_acc_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (rollback_s) begin
            tmp_ptr_d  = wr_ptr_q;
            spec_cnt_d = cmt_cnt_q - CNT_W'(rd_acc_s);
            bad_d      = 1'b0;
        end else if (wr_acc_s) begin
            tmp_ptr_d = ptr_inc(tmp_ptr_q);
            bad_d     = bad_q;
        end else begin
            tmp_ptr_d = tmp_ptr_q;
            bad_d     = bad_q | ovf_s;
        end

        // Commit and rollback are mutually exclusive: commit needs a clean,
        // accepted, non-aborted write.
        if (commit_s) begin
            wr_ptr_d  = ptr_inc(tmp_ptr_q);
            cmt_cnt_d = spec_adv_s;
        end else begin
            wr_ptr_d  = wr_ptr_q;
        end

        free_cnt_d = DEPTH_C - spec_cnt_d;
    end

    // State, registered flags/counts and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= ADDR_W'(0);
            wr_ptr_q   <= ADDR_W'(0);
            tmp_ptr_q  <= ADDR_W'(0);
            spec_cnt_q <= CNT_W'(0);
            cmt_cnt_q  <= CNT_W'(0);
            bad_q      <= 1'b0;
            full_q     <= 1'b0;
            afull_q    <= (DEPTH_C <= AF_C);
            empty_q    <= 1'b1;
            data_cnt_q <= CNT_W'(0);
            free_cnt_q <= DEPTH_C;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tmp_ptr_q  <= tmp_ptr_d;
            spec_cnt_q <= spec_cnt_d;
            cmt_cnt_q  <= cmt_cnt_d;
            bad_q      <= bad_d;
            full_q     <= (spec_cnt_d == DEPTH_C);
            afull_q    <= (free_cnt_d <= AF_C);
            empty_q    <= (cmt_cnt_d == CNT_W'(0));
            data_cnt_q <= cmt_cnt_d;
            free_cnt_q <= free_cnt_d;
            drop_q     <= drop_s;
            ovf_q      <= ovf_s;
        end
    end

    // Storage: written at the speculative pointer, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
                eot_mem_q[i] <= 1'b0;
`endif
            end
        end else if (wr_acc_s) begin
            mem_q[tmp_ptr_q] <= data_in;
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
            eot_mem_q[tmp_ptr_q] <= eot;
`endif
        end else begin
            mem_q[tmp_ptr_q] <= mem_q[tmp_ptr_q];
        end
    end

    assign full     = full_q;
    assign full_n   = ~full_q;
    assign afull    = afull_q;
    assign empty    = empty_q;
    assign empty_n  = ~empty_q;
    assign data_cnt = data_cnt_q;
    assign free_cnt = free_cnt_q;
    assign drop     = drop_q;
    assign ovf      = ovf_q;
    assign data_out = mem_q[rd_ptr_q];
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
    assign rd_eot   = eot_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_sfifo_pkt_abt.sv
// Directed self-checking bench for sfifo_pkt_abt: a DEPTH=4 instance for the
// commit/abort/overflow/afull/reset scenarios and a DEPTH=5 instance for
// pointer wrap at a non power-of-two depth.
module tb_sfifo_pkt_abt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // DEPTH=4 instance signals
    logic       wr_en = 1'b0, eot = 1'b0, abort = 1'b0, rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       full, full_n, afull, empty, empty_n, drop, ovf;
    logic [7:0] data_out;
    logic [2:0] data_cnt, free_cnt;
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
    logic       rd_eot, f5_rd_eot;
`endif

    // DEPTH=5 instance signals
    logic       f5_wr_en = 1'b0, f5_eot = 1'b0, f5_abort = 1'b0, f5_rd_en = 1'b0;
    logic [7:0] f5_data_in = 8'h00;
    logic       f5_full, f5_full_n, f5_afull, f5_empty, f5_empty_n, f5_drop, f5_ovf;
    logic [7:0] f5_data_out;
    logic [3:0] f5_data_cnt, f5_free_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sfifo_pkt_abt #(.DEPTH(4), .WIDTH(8), .AF_MARGIN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .eot(eot),
        .abort(abort), .full(full), .full_n(full_n), .afull(afull),
        .empty(empty), .empty_n(empty_n), .rd_en(rd_en), .data_out(data_out),
        .data_cnt(data_cnt), .free_cnt(free_cnt),
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
        .rd_eot(rd_eot),
`endif
        .drop(drop), .ovf(ovf)
    );

    sfifo_pkt_abt #(.DEPTH(5), .WIDTH(8), .AF_MARGIN(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(f5_wr_en), .data_in(f5_data_in), .eot(f5_eot),
        .abort(f5_abort), .full(f5_full), .full_n(f5_full_n), .afull(f5_afull),
        .empty(f5_empty), .empty_n(f5_empty_n), .rd_en(f5_rd_en), .data_out(f5_data_out),
        .data_cnt(f5_data_cnt), .free_cnt(f5_free_cnt),
`ifdef SFIFO_PKT_ABT_RD_EOT_EN
        .rd_eot(f5_rd_eot),
`endif
        .drop(f5_drop), .ovf(f5_ovf)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; eot = 1'b0; abort = 1'b0; rd_en = 1'b0;
        f5_wr_en = 1'b0; f5_eot = 1'b0; f5_abort = 1'b0; f5_rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr_word(input logic [7:0] d, input logic e);
        wr_en = 1'b1; data_in = d; eot = e;
        step();
        wr_en = 1'b0; eot = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_empty"},   32'(empty),    32'd1);
        check_eq({tag, "_empty_n"}, 32'(empty_n),  32'd0);
        check_eq({tag, "_full"},    32'(full),     32'd0);
        check_eq({tag, "_full_n"},  32'(full_n),   32'd1);
        check_eq({tag, "_afull"},   32'(afull),    32'd0);
        check_eq({tag, "_dcnt"},    32'(data_cnt), 32'd0);
        check_eq({tag, "_fcnt"},    32'(free_cnt), 32'd4);
        check_eq({tag, "_dout"},    32'(data_out), 32'h00);
        check_eq({tag, "_drop"},    32'(drop),     32'd0);
        check_eq({tag, "_ovf"},     32'(ovf),      32'd0);
    endtask

    // Three-word packet, then read it back.
    task automatic scen_basic(input string tag);
        wr_word(8'h11, 1'b0);
        check_eq({tag, "_w1_empty"}, 32'(empty), 32'd1);
        check_eq({tag, "_w1_fcnt"},  32'(free_cnt), 32'd3);
        wr_word(8'h22, 1'b0);
        check_eq({tag, "_w2_empty"}, 32'(empty), 32'd1);
        wr_word(8'h33, 1'b1);
        check_eq({tag, "_eot_empty"}, 32'(empty), 32'd0);
        check_eq({tag, "_eot_dcnt"},  32'(data_cnt), 32'd3);
        check_eq({tag, "_eot_fcnt"},  32'(free_cnt), 32'd1);
        check_eq({tag, "_eot_afull"}, 32'(afull), 32'd1);
        check_eq({tag, "_head0"},     32'(data_out), 32'h11);
        rd_en = 1'b1;
        step();
        check_eq({tag, "_head1"}, 32'(data_out), 32'h22);
        check_eq({tag, "_r1_dcnt"}, 32'(data_cnt), 32'd2);
        step();
        check_eq({tag, "_head2"}, 32'(data_out), 32'h33);
        step();
        rd_en = 1'b0;
        check_eq({tag, "_r3_empty"}, 32'(empty), 32'd1);
        check_eq({tag, "_r3_fcnt"},  32'(free_cnt), 32'd4);
        check_eq({tag, "_r3_dcnt"},  32'(data_cnt), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_state("rst");

        // 1: basic commit and read
        scen_basic("s1");

        // 2: abort while presenting a word
        do_reset();
        wr_word(8'hB0, 1'b0);
        wr_word(8'hB1, 1'b0);
        check_eq("s2_pre_fcnt", 32'(free_cnt), 32'd2);
        wr_en = 1'b1; abort = 1'b1; data_in = 8'hEE;
        step();
        wr_en = 1'b0; abort = 1'b0;
        check_eq("s2_abt_fcnt",  32'(free_cnt), 32'd4);
        check_eq("s2_abt_empty", 32'(empty), 32'd1);
        wr_word(8'hC0, 1'b1);
        check_eq("s2_pkt_dcnt", 32'(data_cnt), 32'd1);
        check_eq("s2_pkt_dout", 32'(data_out), 32'hC0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_eq("s2_rd_empty", 32'(empty), 32'd1);

        // 3: overflow poisons packet, dropped at EOT
        do_reset();
        wr_word(8'h01, 1'b0);
        wr_word(8'h02, 1'b0);
        wr_word(8'h03, 1'b0);
        wr_word(8'h04, 1'b0);
        check_eq("s3_full",   32'(full), 32'd1);
        check_eq("s3_full_n", 32'(full_n), 32'd0);
        check_eq("s3_fcnt0",  32'(free_cnt), 32'd0);
        check_eq("s3_ovf0",   32'(ovf), 32'd0);
        wr_word(8'h05, 1'b1);
        check_eq("s3_ovf",   32'(ovf), 32'd1);
        check_eq("s3_drop",  32'(drop), 32'd1);
        check_eq("s3_full1", 32'(full), 32'd0);
        check_eq("s3_fcnt",  32'(free_cnt), 32'd4);
        check_eq("s3_empty", 32'(empty), 32'd1);
        wr_word(8'h77, 1'b1);
        check_eq("s3_ovf_end",  32'(ovf), 32'd0);
        check_eq("s3_drop_end", 32'(drop), 32'd0);
        check_eq("s3_good_dcnt", 32'(data_cnt), 32'd1);
        check_eq("s3_good_dout", 32'(data_out), 32'h77);

        // 4: DEPTH=5 streaming with wrap
        do_reset();
        f5_wr_en = 1'b1; f5_eot = 1'b1; f5_rd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            f5_data_in = 8'(8'h40 + i);
            step();
            check_eq($sformatf("s4_dout%0d", i), 32'(f5_data_out), 32'(8'h40 + i));
            check_eq($sformatf("s4_dcnt%0d", i), 32'(f5_data_cnt), 32'd1);
            check_eq($sformatf("s4_full%0d", i), 32'(f5_full), 32'd0);
        end
        f5_wr_en = 1'b0; f5_eot = 1'b0;
        step();
        f5_rd_en = 1'b0;
        check_eq("s4_end_empty", 32'(f5_empty), 32'd1);
        check_eq("s4_end_fcnt",  32'(f5_free_cnt), 32'd5);

        // 5: almost-full and abort release
        do_reset();
        wr_word(8'h21, 1'b0);
        wr_word(8'h22, 1'b0);
        check_eq("s5_afull2", 32'(afull), 32'd0);
        wr_word(8'h23, 1'b0);
        check_eq("s5_afull3", 32'(afull), 32'd1);
        check_eq("s5_full3",  32'(full), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("s5_abt_afull", 32'(afull), 32'd0);
        check_eq("s5_abt_fcnt",  32'(free_cnt), 32'd4);

        // 6: asynchronous reset mid-packet
        do_reset();
        wr_word(8'hA1, 1'b0);
        wr_word(8'hA2, 1'b1);
        wr_word(8'hA3, 1'b0);
        check_eq("s6_pre_dcnt", 32'(data_cnt), 32'd2);
        check_eq("s6_pre_fcnt", 32'(free_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("s6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        scen_basic("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
